fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 132 +++++++++++++
 tb/tb_fetch_queue.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: FSM state encoding, HLT opcode, PC step
// and the queue entry layout.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   localparam logic [3:0]  OPC_HLT = 4'hF;
   localparam logic [15:0] PC_STEP = 16'd2;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer with read/write pointers and an occupancy count.
// Flush empties the buffer in one cycle and wins over any push/pop.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      flush,
   input  logic      push,
   input  fq_entry_t wdata,
   input  logic      pop,
   output fq_entry_t head,
   output logic      empty,
   output logic      full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fq_entry_t      mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [CW-1:0]  count;
   logic           do_push;
   logic           do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding memory request at a time,
// responses land in fetch_fifo, decode pops from the head.
// Optional feature: define FETCH_HLT_DETECT_EN to stop fetching after an
// opcode-F (HLT) word is enqueued.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no request outstanding; issue when the queue has a free slot
// WAIT    | request outstanding at req_addr; discard marks a stale one
// HALT    | HLT word fetched; no requests until redirect
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_rvalid,
   input  logic [15:0] mem_rdata,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr_out,
   output logic [15:0] instr_pc,
   output logic        hlt
);

   fetch_state_e state;
   fetch_state_e state_nx;
   logic [15:0]  fetch_pc;
   logic [15:0]  fetch_pc_nx;
   logic [15:0]  req_addr;
   logic [15:0]  req_addr_nx;
   logic         discard;
   logic         discard_nx;
   logic         push;
   logic         q_empty;
   logic         q_full;
   fq_entry_t    head;
   fq_entry_t    push_entry;

   assign push_entry = '{instr: mem_rdata, pc: req_addr};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect),
      .push  (push),
      .wdata (push_entry),
      .pop   (instr_ready),
      .head  (head),
      .empty (q_empty),
      .full  (q_full)
   );

   // State, fetch address, latched request address and stale-response flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
         discard  <= 1'b0;
      end else begin
         state    <= state_nx;
         fetch_pc <= fetch_pc_nx;
         req_addr <= req_addr_nx;
         discard  <= discard_nx;
      end
   end

   // Next-state logic: issue, accept or drop a response, and redirect handling.
   always_comb begin
      state_nx    = state;
      fetch_pc_nx = fetch_pc;
      req_addr_nx = req_addr;
      discard_nx  = discard;
      push        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (redirect) begin
               fetch_pc_nx = redirect_pc;
            end else if (!q_full) begin
               state_nx    = ST_WAIT;
               req_addr_nx = fetch_pc;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               state_nx   = ST_IDLE;
               discard_nx = 1'b0;
               if (redirect) begin
                  fetch_pc_nx = redirect_pc;
               end else if (!discard) begin
                  push        = 1'b1;
                  fetch_pc_nx = fetch_pc + PC_STEP;
`ifdef FETCH_HLT_DETECT_EN
                  if (mem_rdata[15:12] == OPC_HLT) state_nx = ST_HALT;
`endif
               end
            end else if (redirect) begin
               // Memory still owes us this response; keep mem_req up and drop it.
               discard_nx  = 1'b1;
               fetch_pc_nx = redirect_pc;
            end
         end
         ST_HALT: begin
            if (redirect) begin
               state_nx    = ST_IDLE;
               fetch_pc_nx = redirect_pc;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign mem_req     = (state == ST_WAIT);
   assign mem_addr    = mem_req ? req_addr : fetch_pc;
   assign instr_valid = !q_empty;
   assign instr_out   = head.instr;
   assign instr_pc    = head.pc;

`ifdef FETCH_HLT_DETECT_EN
   assign hlt = (state == ST_HALT);
`else
   assign hlt = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-level reference model and a
// simple latency-programmable instruction memory.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [15:0] RESET_PC = 16'h0000;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
   } ent_t;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr_out;
   logic [15:0] instr_pc;
   logic        hlt;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .hlt         (hlt)
   );

   int vectors     = 0;
   int miscompares = 0;
   int latency     = 1;

   logic [15:0] imem [logic [15:0]];
   ent_t        mq[$];
   ent_t        popped[$];
   logic [15:0] reqs[$];
   int          n_req;
   bit          m_out, m_disc, m_halted, m_just_disc;
   logic [15:0] m_next_pc, m_req_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] word_at(input logic [15:0] a);
      if (imem.exists(a)) return imem[a];
      return {4'h2, a[11:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Instruction memory: answers each request after `latency` cycles.
   initial begin : responder
      bit pending = 0;
      int wait_left = 0;
      logic [15:0] rsp_addr = '0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (rst) begin
            pending = 0;
         end else if (mem_req) begin
            if (!pending) begin
               pending   = 1;
               wait_left = latency - 1;
               rsp_addr  = mem_addr;
            end else begin
               wait_left--;
            end
            if (wait_left <= 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = word_at(rsp_addr);
               pending    = 0;
            end
         end else begin
            pending = 0;
         end
      end
   end

   // Reference model and per-cycle compare, sampled just before each rising edge.
   initial begin : model
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            mq.delete();
            m_out = 0; m_disc = 0; m_halted = 0; m_just_disc = 0;
            m_next_pc = RESET_PC;
            continue;
         end
         chk("instr_valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
         if (mq.size() != 0) begin
            chk("instr_pc", {16'd0, instr_pc}, {16'd0, mq[0].pc});
            chk("instr_out", {16'd0, instr_out}, {16'd0, mq[0].instr});
         end
         chk("hlt", {31'd0, hlt}, {31'd0, m_halted});
         if (mem_req) begin
            if (!m_out) begin
               chk("req_addr", {16'd0, mem_addr}, {16'd0, m_next_pc});
               if (mq.size() >= DEPTH) chk("req_when_full", {31'd0, mem_req}, 32'd0);
               if (m_halted)           chk("req_when_halted", {31'd0, mem_req}, 32'd0);
               if (m_just_disc)        chk("req_right_after_discard", {31'd0, mem_req}, 32'd0);
               m_out      = 1;
               m_req_addr = mem_addr;
               reqs.push_back(mem_addr);
               n_req++;
            end else begin
               chk("addr_stable", {16'd0, mem_addr}, {16'd0, m_req_addr});
            end
         end else if (m_out) begin
            chk("mem_req_held", {31'd0, mem_req}, 32'd1);
         end

         m_just_disc = 0;
         if (redirect) begin
            mq.delete();
            m_next_pc = redirect_pc;
            m_halted  = 0;
            if (m_out && mem_rvalid) begin
               m_out = 0; m_disc = 0; m_just_disc = 1;
            end else if (m_out) begin
               m_disc = 1;
            end
         end else begin
            if (mq.size() != 0 && instr_ready) begin
               popped.push_back('{instr: instr_out, pc: instr_pc});
               void'(mq.pop_front());
            end
            if (m_out && mem_rvalid) begin
               m_out = 0;
               if (m_disc) begin
                  m_disc = 0; m_just_disc = 1;
               end else begin
                  mq.push_back('{instr: word_at(m_req_addr), pc: m_req_addr});
                  m_next_pc = m_req_addr + 16'd2;
`ifdef FETCH_HLT_DETECT_EN
                  if (word_at(m_req_addr) >= 16'hF000) m_halted = 1;
`endif
               end
            end
         end
      end
   end

   task automatic clear_logs();
      popped.delete();
      reqs.delete();
      n_req = 0;
   endtask

   // Reset with literal checks of the reset values; leaves rst low at a negedge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; redirect = 1'b0; instr_ready = 1'b0; redirect_pc = '0;
      @(negedge clk);
      #4;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, {16'd0, RESET_PC});
      chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr_out", {16'd0, instr_out}, 32'd0);
      chk("rst_instr_pc", {16'd0, instr_pc}, 32'd0);
      chk("rst_hlt", {31'd0, hlt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_popped(input int n, input string name);
      int k = 0;
      while (popped.size() < n && k < 200) begin @(negedge clk); k++; end
      if (popped.size() < n) chk({name, "_timeout"}, popped.size(), n);
   endtask

   task automatic wait_reqs(input int n, input string name);
      int k = 0;
      while (reqs.size() < n && k < 200) begin @(negedge clk); k++; end
      if (reqs.size() < n) chk({name, "_timeout"}, reqs.size(), n);
   endtask

   task automatic pulse_redirect(input logic [15:0] pc);
      redirect = 1'b1; redirect_pc = pc;
      @(negedge clk);
      redirect = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int k;
      bit found;
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      n_req = 0;

      // Two-word stream at 1-cycle latency, decode always ready.
      imem.delete();
      imem[16'h0000] = 16'hB102;
      imem[16'h0002] = 16'hA100;
      latency = 1;
      do_reset();
      instr_ready = 1'b1;
      wait_popped(2, "seq");
      if (popped.size() >= 2) begin
         chk("seq0_instr", {16'd0, popped[0].instr}, 32'h0000B102);
         chk("seq0_pc", {16'd0, popped[0].pc}, 32'h00000000);
         chk("seq1_instr", {16'd0, popped[1].instr}, 32'h0000A100);
         chk("seq1_pc", {16'd0, popped[1].pc}, 32'h00000002);
      end

      // Back-pressure: queue fills with DEPTH requests, one pop frees one slot.
      imem.delete();
      latency = 1;
      do_reset();
      run(30);
      chk("full_nreq", n_req, 4);
      chk("full_mem_req", {31'd0, mem_req}, 32'd0);
      chk("full_valid", {31'd0, instr_valid}, 32'd1);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      run(20);
      chk("pop_nreq", n_req, 5);
      chk("pop_mem_req", {31'd0, mem_req}, 32'd0);
      chk("pop_count", popped.size(), 1);

      // Redirect during WAIT with 3-cycle latency: stale response dropped.
      latency = 3;
      do_reset();
      k = 0;
      while (!(n_req == 3 && mem_req) && k < 200) begin @(negedge clk); #1; k++; end
      chk("redir_wait_reached", n_req, 3);
      pulse_redirect(16'h0004);
      reqs.delete();
      #4;
      chk("redir_empty", {31'd0, instr_valid}, 32'd0);
      wait_reqs(1, "redir_req");
      if (reqs.size() >= 1) chk("redir_next_addr", {16'd0, reqs[0]}, 32'h00000004);
      instr_ready = 1'b1;
      wait_popped(1, "redir_pop");
      if (popped.size() >= 1) begin
         chk("redir_first_pc", {16'd0, popped[0].pc}, 32'h00000004);
         chk("redir_first_instr", {16'd0, popped[0].instr}, 32'h00002004);
      end

      // Redirect coinciding with a response and a pop.
      latency = 2;
      do_reset();
      k = 0;
      while (!(n_req == 3 && mem_rvalid) && k < 200) begin @(negedge clk); #1; k++; end
      chk("coinc_rvalid_seen", {31'd0, mem_rvalid}, 32'd1);
      chk("coinc_valid_before", {31'd0, instr_valid}, 32'd1);
      instr_ready = 1'b1;
      pulse_redirect(16'h0100);
      popped.delete();
      reqs.delete();
      #4;
      chk("coinc_empty", {31'd0, instr_valid}, 32'd0);
      wait_reqs(1, "coinc_req");
      if (reqs.size() >= 1) chk("coinc_next_addr", {16'd0, reqs[0]}, 32'h00000100);
      wait_popped(1, "coinc_pop");
      if (popped.size() >= 1) chk("coinc_first_pc", {16'd0, popped[0].pc}, 32'h00000100);

      // Address wrap at the top of memory.
      latency = 1;
      do_reset();
      instr_ready = 1'b1;
      pulse_redirect(16'hFFFE);
      popped.delete();
      wait_popped(2, "wrap");
      if (popped.size() >= 2) begin
         chk("wrap0_pc", {16'd0, popped[0].pc}, 32'h0000FFFE);
         chk("wrap0_instr", {16'd0, popped[0].instr}, 32'h00002FFE);
         chk("wrap1_pc", {16'd0, popped[1].pc}, 32'h00000000);
      end

      // Reset mid-request takes priority over a simultaneous redirect.
      latency = 3;
      do_reset();
      k = 0;
      while (!mem_req && k < 50) begin @(negedge clk); k++; end
      rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
      @(negedge clk);
      redirect = 1'b0;
      #4;
      chk("rstprio_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rstprio_mem_addr", {16'd0, mem_addr}, {16'd0, RESET_PC});
      @(negedge clk);
      rst = 1'b0;
      clear_logs();
      wait_reqs(1, "rstprio_req");
      if (reqs.size() >= 1) chk("rstprio_first_addr", {16'd0, reqs[0]}, 32'h00000000);

      // HLT opcode stream.
      imem.delete();
      imem[16'h0000] = 16'h0462;
      imem[16'h0002] = 16'hF000;
      imem[16'h0004] = 16'h1462;
      latency = 1;
      do_reset();
      instr_ready = 1'b1;
      run(20);
      if (popped.size() >= 2) begin
         chk("hlt_word_instr", {16'd0, popped[1].instr}, 32'h0000F000);
         chk("hlt_word_pc", {16'd0, popped[1].pc}, 32'h00000002);
      end else begin
         chk("hlt_pop_count", popped.size(), 2);
      end
      found = 0;
      foreach (reqs[i]) if (reqs[i] == 16'h0004) found = 1;
`ifdef FETCH_HLT_DETECT_EN
      chk("hlt_asserted", {31'd0, hlt}, 32'd1);
      chk("hlt_no_fetch_after", {31'd0, found}, 32'd0);
      pulse_redirect(16'h0000);
      #4;
      chk("hlt_cleared", {31'd0, hlt}, 32'd0);
      popped.delete();
      wait_popped(1, "hlt_resume");
      if (popped.size() >= 1) chk("hlt_resume_pc", {16'd0, popped[0].pc}, 32'h00000000);
`else
      chk("hlt_off", {31'd0, hlt}, 32'd0);
      chk("hlt_off_fetch_after", {31'd0, found}, 32'd1);
      if (popped.size() >= 3) begin
         chk("hlt_off_next_instr", {16'd0, popped[2].instr}, 32'h00001462);
         chk("hlt_off_next_pc", {16'd0, popped[2].pc}, 32'h00000004);
      end else begin
         chk("hlt_off_pop_count", popped.size(), 3);
      end
`endif

      run(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
